lsu_access_unit: RTL
====================

# lsu_access_unit

Parametrised, sequential load/store alignment unit between the MIPS execute stage and the instruction/data block memories. It accepts one load or store request at a time, issues one or two memory beats, and returns a sign- or zero-extended load result or a store acknowledge. It generalises store lane placement and load byte/half extraction to any power-of-two data width. Accesses that cross a beat boundary are split into two beats.

## Interface
- DATA_W, 32, memory beat width in bits; power of two, ≥32; NB = DATA_W/8 lanes, OFF_W = log2(NB)
- MEM_ADR_W, 12, memory word-address width
- Clock  in  1  single clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle and can accept
- req_op  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- mem_adr  out  MEM_ADR_W  beat word address
- mem_we_i  out  NB  imem lane write enables
- mem_we_d  out  NB  dmem lane write enables
- mem_wdata  out  DATA_W  lane-placed store data
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_adr
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_data  out  32  load result; 0 for stores
- rsp_err  out  1  misaligned access rejected

## Operation
- Handshake: transfer when req_valid && req_ready. req_ready = (state == IDLE). Request latched on acceptance. Memory outputs are driven only from registered state and the latched request, never from req_* directly.
- Size: byte = 1, half = 2, word = 4. off = addr[OFF_W-1:0]. mem_adr = addr[MEM_ADR_W+OFF_W-1:OFF_W].
- Big-endian lanes: offset k maps to we bit NB-1-k and data bits [DATA_W-1-8k -: 8].
- Region: we_d asserted when addr[28] = 1. we_i asserted when addr[29] = 1. Both can be set. Loads read mem_rdata only.
- Split when off + size > NB:
  - beat0 covers lanes off..NB-1 at mem_adr.
  - beat1 covers lanes 0..off+size-NB-1 at mem_adr+1; the address wraps modulo 2^MEM_ADR_W.
- Loads: the selected bytes are concatenated MSB-first. LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- FSM states: IDLE, BEAT0, BEAT1, CAPT, RESP.
  - IDLE → BEAT0 on accept; → RESP directly if rejected as misaligned.
  - BEAT0 → BEAT1 if split, else CAPT for a load, else RESP.
  - BEAT1 → CAPT for a load, else RESP. A split load captures the beat0 rdata while in BEAT1.
  - CAPT captures rdata. CAPT → RESP.
  - RESP → IDLE.
- Write enables are nonzero only in BEAT0/BEAT1 for stores.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0, mem_we_i 0, mem_we_d 0, mem_adr 0, mem_wdata 0.
- Reset mid-operation: write enables drop immediately (asynchronous). The request is discarded with no response.

## Timing
- Cycle t0 is the accept edge.
- Aligned store: beat at t1, rsp at t2.
- Aligned load: address at t1, rdata at t2 (CAPT), rsp at t3.
- Split store: beats at t1 and t2, rsp at t3.
- Split load: beats at t1 and t2, rsp at t4.
- Rejected access: rsp at t1 with rsp_err = 1. No memory beat is issued.
- Throughput: one request in flight. The next request can be accepted in the cycle after RESP.

## Configuration
- LSU_MISALIGN_EN defined: split accesses run as two beats as described above.
- LSU_MISALIGN_EN undefined: any access with off + size > NB is rejected.
  - No memory access is issued; write enables stay 0.
  - rsp_err = 1 and rsp_data = 0 at t1.
  - The BEAT1 state is not compiled in.

## Structure
- Package lsu_pkg holds:
  - op encoding localparams
  - size-decode function
  - FSM state enum
  - region bit positions (28, 29)
- Sub-module lsu_lane_shift is purely combinational and covers:
  - store lane placement
  - per-beat enable mask generation
  - load byte gathering and extension
- lsu_access_unit holds the FSM, the request latch and the capture registers.

## Test plan
- SB, addr 0x70000005, wdata 0xdeadbeef → t1: mem_adr 0x001, we_i = we_d = 0100, mem_wdata[23:16] = 0xef; t2: rsp_valid, rsp_err 0.
- Memory word 1 = 0xdeadbeef:
  - LB 0x10000006 → rsp_data 0xffffffbe at t3.
  - LBU at the same address → 0x000000be.
- Same word:
  - LHU 0x10000004 → 0x0000dead.
  - LH 0x10000006 → 0xffffbeef.
  - LW 0x10000004 → 0xdeadbeef.
- Split LW 0x10000006, words 1 = 0xdeadbeef and 2 = 0x01234567 (LSU_MISALIGN_EN defined) → rsp 0xbeef0123 at t4.
  - With the macro undefined: rsp_err 1 at t1, no beats issued.
- Split SW 0x10000007, wdata 0xaabbccdd:
  - beat0: adr 1, we_d 0001, wdata[7:0] = aa.
  - beat1: adr 2, we_d 1110, wdata[31:8] = bbccdd.
  - Same SW at mem_adr 0xfff: beat1 goes to 0x000.
- Reset pulsed during BEAT1 of a split store → write enables 0 within the same cycle, no rsp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: op codes, size decode, FSM states.
// Build option LSU_MISALIGN_EN adds the BEAT1 state used by beat-crossing accesses.
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  localparam int REGION_DMEM_BIT = 28;
  localparam int REGION_IMEM_BIT = 29;

`ifdef LSU_MISALIGN_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;
`endif

  // Access size in bytes: 1, 2 or 4.
  function automatic logic [2:0] lsu_size(input logic [2:0] op);
    logic [2:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = 3'd1;
      OP_LH, OP_LHU, OP_SH: sz = 3'd2;
      default:              sz = 3'd4;
    endcase
    return sz;
  endfunction

  function automatic logic lsu_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Combinational lane steering: big-endian store placement, per-beat byte masks and
// load gathering/extension over a two-beat window (beat0 lanes first, then beat1).
module lsu_lane_shift
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [2:0]        op_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [31:0]       wdata_i,
  input  logic [DATA_W-1:0] rdata0_i,
  input  logic [DATA_W-1:0] rdata1_i,
  output logic              split_o,
  output logic [NB-1:0]     mask0_o,
  output logic [NB-1:0]     mask1_o,
  output logic [DATA_W-1:0] wdata0_o,
  output logic [DATA_W-1:0] wdata1_o,
  output logic [31:0]       load_o
);

  logic [2:0]            size;
  logic [OFF_W+2:0]      bit_sh;
  logic [5:0]            pad_bits;
  logic [2*NB-1:0]       mask_top;
  logic [2*NB-1:0]       mask_win;
  logic [31:0]           wd_just;
  logic [2*DATA_W-1:0]   wd_win;
  logic [2*DATA_W-1:0]   rd_win;
  logic [31:0]           raw;

  assign size     = lsu_size(op_i);
  assign bit_sh   = {off_i, 3'b000};
  assign pad_bits = 6'd32 - {size, 3'b000};

  // Lane 0 of the window is its MSB; shifting right by the offset moves bytes to higher lanes.
  always_comb begin
    mask_top = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < size) mask_top[2*NB-1-i] = 1'b1;
    end
  end

  assign mask_win = mask_top >> off_i;
  assign mask0_o  = mask_win[2*NB-1:NB];
  assign mask1_o  = mask_win[NB-1:0];
  assign split_o  = |mask1_o;

  assign wd_just  = wdata_i << pad_bits;
  assign wd_win   = {wd_just, {(2*DATA_W-32){1'b0}}} >> bit_sh;
  assign wdata0_o = wd_win[2*DATA_W-1:DATA_W];
  assign wdata1_o = wd_win[DATA_W-1:0];

  assign rd_win = {rdata0_i, rdata1_i} << bit_sh;
  assign raw    = rd_win[2*DATA_W-1 -: 32];

  always_comb begin
    load_o = '0;
    case (op_i)
      OP_LB:   load_o = {{24{raw[31]}}, raw[31:24]};
      OP_LBU:  load_o = {24'h0, raw[31:24]};
      OP_LH:   load_o = {{16{raw[31]}}, raw[31:16]};
      OP_LHU:  load_o = {16'h0, raw[31:16]};
      OP_LW:   load_o = raw;
      default: load_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_access_unit.sv
// Sequential load/store alignment unit: one request at a time, one or two memory beats.
// Define LSU_MISALIGN_EN to split beat-crossing accesses; otherwise they are rejected with rsp_err.
module lsu_access_unit
  import lsu_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int MEM_ADR_W = 12,
  localparam int NB        = DATA_W / 8,
  localparam int OFF_W     = $clog2(NB)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_op_i,
  input  logic [31:0]          req_addr_i,
  input  logic [31:0]          req_wdata_i,
  output logic [MEM_ADR_W-1:0] mem_adr_o,
  output logic [NB-1:0]        mem_we_i_o,
  output logic [NB-1:0]        mem_we_d_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_data_o,
  output logic                 rsp_err_o
);

  lsu_state_e           state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [MEM_ADR_W-1:0] adr_q, adr_d;
  logic [OFF_W-1:0]     off_q, off_d;
  logic                 dmem_en_q, dmem_en_d;
  logic                 imem_en_q, imem_en_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 req_reject;
  logic                 is_store;
  logic                 split;
  logic [NB-1:0]        mask0, mask1;
  logic [DATA_W-1:0]    wdata0, wdata1;
  logic [DATA_W-1:0]    rdata0;
  logic [31:0]          load_res;
  logic                 addr_unused;

  assign addr_unused = ^{req_addr_i[31:30], req_addr_i[27:MEM_ADR_W+OFF_W]};
  assign is_store    = lsu_is_store(op_q);

`ifdef LSU_MISALIGN_EN
  logic [DATA_W-1:0] beat0_q, beat0_d;

  assign req_reject = 1'b0;
  assign rdata0     = split ? beat0_q : mem_rdata_i;
`else
  logic [OFF_W+1:0] req_end;
  logic             lane_unused;

  assign req_end     = (OFF_W+2)'(req_addr_i[OFF_W-1:0]) + (OFF_W+2)'(lsu_size(req_op_i));
  assign req_reject  = req_end > (OFF_W+2)'(NB);
  assign rdata0      = mem_rdata_i;
  assign lane_unused = ^{split, mask1, wdata1};
`endif

  lsu_lane_shift #(.DATA_W(DATA_W)) u_lane_shift (
    .op_i     (op_q),
    .off_i    (off_q),
    .wdata_i  (wdata_q),
    .rdata0_i (rdata0),
    .rdata1_i (mem_rdata_i),
    .split_o  (split),
    .mask0_o  (mask0),
    .mask1_o  (mask1),
    .wdata0_o (wdata0),
    .wdata1_o (wdata1),
    .load_o   (load_res)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= OP_LB;
      adr_q      <= '0;
      off_q      <= '0;
      dmem_en_q  <= 1'b0;
      imem_en_q  <= 1'b0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef LSU_MISALIGN_EN
      beat0_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      adr_q      <= adr_d;
      off_q      <= off_d;
      dmem_en_q  <= dmem_en_d;
      imem_en_q  <= imem_en_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef LSU_MISALIGN_EN
      beat0_q    <= beat0_d;
`endif
    end
  end

  // Memory-side outputs depend only on state and the latched request, so they are idle-zero.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    adr_d       = adr_q;
    off_d       = off_q;
    dmem_en_d   = dmem_en_q;
    imem_en_d   = imem_en_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef LSU_MISALIGN_EN
    beat0_d     = beat0_q;
`endif
    mem_adr_o   = '0;
    mem_we_i_o  = '0;
    mem_we_d_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d       = req_op_i;
          adr_d      = req_addr_i[MEM_ADR_W+OFF_W-1:OFF_W];
          off_d      = req_addr_i[OFF_W-1:0];
          dmem_en_d  = req_addr_i[REGION_DMEM_BIT];
          imem_en_d  = req_addr_i[REGION_IMEM_BIT];
          wdata_d    = req_wdata_i;
          rsp_data_d = '0;
          rsp_err_d  = req_reject;
          state_d    = req_reject ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        mem_adr_o = adr_q;
        if (is_store) begin
          mem_we_d_o  = dmem_en_q ? mask0 : '0;
          mem_we_i_o  = imem_en_q ? mask0 : '0;
          mem_wdata_o = wdata0;
        end
`ifdef LSU_MISALIGN_EN
        if (split) state_d = BEAT1;
        else       state_d = is_store ? RESP : CAPT;
`else
        state_d = is_store ? RESP : CAPT;
`endif
      end
`ifdef LSU_MISALIGN_EN
      // Beat0 read data arrives here and is parked until beat1 data shows up in CAPT.
      BEAT1: begin
        mem_adr_o = adr_q + 1'b1;
        if (is_store) begin
          mem_we_d_o  = dmem_en_q ? mask1 : '0;
          mem_we_i_o  = imem_en_q ? mask1 : '0;
          mem_wdata_o = wdata1;
        end else begin
          beat0_d = mem_rdata_i;
        end
        state_d = is_store ? RESP : CAPT;
      end
`endif
      CAPT: begin
        rsp_data_d = load_res;
        state_d    = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
